axil_bram_responder: RTL
========================

AXIL_BRAM_RESPONDER -- requirements
Module: axil_bram_responder

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning the data bus width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 SHALL have parameter MEM_ADDR_BITS, default 8, meaning log2 of the word depth (256 words).
REQ-004 SHALL have port ACLK  in  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port ARESET  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports S_AXI_AWADDR in ADDR_W, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: the write address channel.
REQ-007 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: the write data channel.
REQ-008 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: the write response channel.
REQ-009 SHALL have ports S_AXI_ARADDR in ADDR_W, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: the read address channel.
REQ-010 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: the read data channel.

Function
REQ-011 SHALL act as an AXI4-Lite responder, one outstanding write and one outstanding read, with the write and read paths independent.
REQ-012 Write FSM SHALL use states W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_COMMIT, W_RESP.
REQ-013 In W_IDLE, AWREADY=WREADY=1; AW alone -> W_WAIT_DATA; W alone -> W_WAIT_ADDR; both in the same cycle -> W_COMMIT.
REQ-014 W_WAIT_DATA/W_WAIT_ADDR SHALL hold ready only on the missing channel and SHALL capture the address/data/strobe on handshake, then go to W_COMMIT.
REQ-015 W_COMMIT SHALL write the memory word at AWADDR[MEM_ADDR_BITS+1:2] for bytes where WSTRB=1, and SHALL assert BVALID on the next cycle (W_RESP).
REQ-016 BVALID SHALL stay high until BREADY; the FSM returns to W_IDLE on the cycle after the handshake; AWREADY/WREADY SHALL be 0 outside W_IDLE and the wait states.
REQ-017 Read FSM SHALL use states R_IDLE, R_MEM, R_DATA; ARREADY=1 only in R_IDLE.
REQ-018 AR handshake -> R_MEM (synchronous memory read, 1 cycle) -> R_DATA with RVALID=1; the read latency is 2 cycles from the AR handshake to RVALID.
REQ-019 RDATA/RRESP SHALL stay stable while RVALID=1 and RREADY=0; the FSM returns to R_IDLE after the handshake.
REQ-020 A read and a write commit to the same word in the same cycle SHALL return the old data (read-first).
REQ-021 AWADDR/ARADDR bits [1:0] SHALL be ignored; an unaligned address accesses the containing word.
REQ-022 BRESP/RRESP SHALL be 2'b00 (OKAY) for in-range addresses; EXOKAY SHALL never be issued.

Reset
REQ-023 While ARESET=1 at a clock edge, both FSMs SHALL go to their IDLE state, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
REQ-024 The ready outputs SHALL assert on the first edge after ARESET deasserts.
REQ-025 Reset SHALL abort any in-flight transaction without a response; a write not yet in W_COMMIT SHALL NOT modify memory; the memory contents SHALL NOT be cleared.

Configuration
REQ-026 Macro AXIL_BRAM_SLVERR_EN defined: an address with any bit set above MEM_ADDR_BITS+1 SHALL get response SLVERR (2'b10), writes SHALL be dropped, and reads SHALL return 0.
REQ-027 Macro undefined: the upper address bits SHALL be ignored (addresses wrap modulo depth), and all responses SHALL be OKAY.

Structure
REQ-028 Package axil_bram_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants and the write/read FSM state typedefs.
REQ-029 Sub-module axil_bram_mem SHALL be a simple dual-port RAM: one synchronous read port, one byte-enable write port, read-first.

Verification
REQ-030 Writes of 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read-back -> every data value matches and every response is OKAY.
REQ-031 W presented 3 cycles before AW at 0x10 -> memory is written only after the AW handshake, and BVALID rises one cycle after W_COMMIT.
REQ-032 Write 0x11223344 with WSTRB=4'b0101 over 0xFFFFFFFF -> the read returns 0xFF22FF44.
REQ-033 BREADY/RREADY held 0 for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA hold stable, and no new AW/AR is accepted.
REQ-034 Write to 0x400 (depth 256): with the macro -> SLVERR, word 0 unchanged, and a read of 0x400 returns 0 with SLVERR; without the macro -> OKAY, and word 0 is overwritten.
REQ-035 ARESET pulsed while in W_WAIT_DATA -> no BVALID, memory unchanged, and the next full write completes normally.

Source files
------------

// File: rtl/axil_bram_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite BRAM responder.
package axil_bram_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      W_IDLE,
      W_WAIT_DATA,
      W_WAIT_ADDR,
      W_COMMIT,
      W_RESP
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_MEM,
      R_DATA
   } r_state_e;

endpackage

// File: rtl/axil_bram_responder_if.sv
// AXI4-Lite bus bundle; master drives requests, slave drives readies and responses.
interface axil_bram_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic [ADDR_W-1:0]   S_AXI_AWADDR;
   logic [2:0]          S_AXI_AWPROT;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;
   logic [DATA_W-1:0]   S_AXI_WDATA;
   logic [DATA_W/8-1:0] S_AXI_WSTRB;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;
   logic [ADDR_W-1:0]   S_AXI_ARADDR;
   logic [2:0]          S_AXI_ARPROT;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;
   logic [DATA_W-1:0]   S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

endinterface

// File: rtl/axil_bram_mem.sv
// Simple dual-port RAM: synchronous read port, byte-enable write port, read-first.
module axil_bram_mem #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_W    = 32
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [ADDR_BITS-1:0]  rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_BITS-1:0]  wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_be
);

   logic [DATA_W-1:0] mem [2**ADDR_BITS];

   // Non-blocking read and write in one process: a same-word collision returns the old word.
   always_ff @(posedge clk) begin
      if (rd_en)
         rd_data <= mem[rd_addr];
      if (wr_en)
         for (int b = 0; b < DATA_W/8; b++)
            if (wr_be[b])
               mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
   end

endmodule

// File: rtl/axil_bram_responder.sv
// AXI4-Lite responder in front of a BRAM; independent single-outstanding write and read paths.
// Optional AXIL_BRAM_SLVERR_EN: out-of-range addresses get SLVERR, writes dropped, reads return 0.
module axil_bram_responder
   import axil_bram_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int MEM_ADDR_BITS      = 8
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   axil_bram_responder_if.slave  s_axi
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int MA = MEM_ADDR_BITS;

   w_state_e w_state, w_next;
   r_state_e r_state, r_next;

   logic            awready_q, wready_q, bvalid_q;
   logic [1:0]      bresp_q;
   logic            arready_q, rvalid_q;
   logic [1:0]      rresp_q;
   logic [DW-1:0]   rdata_q;

   logic [MA-1:0]   aw_idx_q;
   logic            aw_oor_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] wstrb_q;
   logic            rd_oor_q;
   logic [DW-1:0]   mem_rdata;

   logic aw_hs, w_hs, ar_hs;
   logic aw_cap, w_cap, mem_we;
   logic aw_oor, ar_oor;
   logic unused_ok;

`ifdef AXIL_BRAM_SLVERR_EN
   assign aw_oor = |s_axi.S_AXI_AWADDR[AW-1:MA+2];
   assign ar_oor = |s_axi.S_AXI_ARADDR[AW-1:MA+2];
   assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
`else
   // Upper bits ignored: addresses wrap modulo the depth.
   assign aw_oor = 1'b0;
   assign ar_oor = 1'b0;
   assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                        s_axi.S_AXI_AWADDR[AW-1:MA+2], s_axi.S_AXI_ARADDR[AW-1:MA+2]};
`endif

   // Readies are registered so they stay low through reset and rise on the first edge after it.
   assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
   assign w_hs  = s_axi.S_AXI_WVALID  & wready_q;
   assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;

   // Write path
   always_comb begin
      w_next = w_state;
      aw_cap = 1'b0;
      w_cap  = 1'b0;
      mem_we = 1'b0;
      case (w_state)
         W_IDLE: begin
            aw_cap = aw_hs;
            w_cap  = w_hs;
            if (aw_hs && w_hs) w_next = W_COMMIT;
            else if (aw_hs)    w_next = W_WAIT_DATA;
            else if (w_hs)     w_next = W_WAIT_ADDR;
         end
         W_WAIT_DATA: begin
            w_cap = w_hs;
            if (w_hs) w_next = W_COMMIT;
         end
         W_WAIT_ADDR: begin
            aw_cap = aw_hs;
            if (aw_hs) w_next = W_COMMIT;
         end
         W_COMMIT: begin
            mem_we = ~aw_oor_q;
            w_next = W_RESP;
         end
         W_RESP: begin
            if (s_axi.S_AXI_BREADY) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state   <= w_next;
         awready_q <= (w_next == W_IDLE) || (w_next == W_WAIT_ADDR);
         wready_q  <= (w_next == W_IDLE) || (w_next == W_WAIT_DATA);
         bvalid_q  <= (w_next == W_RESP);
         if (w_state == W_COMMIT)
            bresp_q <= aw_oor_q ? RESP_SLVERR : RESP_OKAY;
      end
   end

   always_ff @(posedge ACLK) begin
      if (aw_cap) begin
         aw_idx_q <= s_axi.S_AXI_AWADDR[MA+1:2];
         aw_oor_q <= aw_oor;
      end
      if (w_cap) begin
         wdata_q <= s_axi.S_AXI_WDATA;
         wstrb_q <= s_axi.S_AXI_WSTRB;
      end
   end

   // Read path: RAM is addressed straight from ARADDR on the handshake edge.
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_MEM;
         R_MEM:   r_next = R_DATA;
         R_DATA:  if (s_axi.S_AXI_RREADY) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         rd_oor_q  <= 1'b0;
      end else begin
         r_state   <= r_next;
         arready_q <= (r_next == R_IDLE);
         rvalid_q  <= (r_next == R_DATA);
         if (ar_hs)
            rd_oor_q <= ar_oor;
         if (r_state == R_MEM) begin
            rdata_q <= rd_oor_q ? '0 : mem_rdata;
            rresp_q <= rd_oor_q ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   axil_bram_mem #(
      .ADDR_BITS (MA),
      .DATA_W    (DW)
   ) u_mem (
      .clk     (ACLK),
      .rd_en   (ar_hs),
      .rd_addr (s_axi.S_AXI_ARADDR[MA+1:2]),
      .rd_data (mem_rdata),
      .wr_en   (mem_we),
      .wr_addr (aw_idx_q),
      .wr_data (wdata_q),
      .wr_be   (wstrb_q)
   );

endmodule
